rggen_register_initiator: RTL and testbench

//  Bus-initiator side of the register interface consumed by generated register blocks and their bit fields.

---
 rtl/rggen_register_initiator_pkg.sv | 14 +
 rtl/rggen_access_timer.sv | 27 ++
 rtl/rggen_register_initiator.sv | 171 +++++++++++++++++
 tb/tb_rggen_register_initiator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_register_initiator_pkg.sv
// Shared access and status codes for the register initiator.
package rggen_register_initiator_pkg;

    // Access codes driven on o_register_access (bit 1: non-posted, bit 0: data direction).
    localparam logic [1:0] RGGEN_READ  = 2'b10;
    localparam logic [1:0] RGGEN_WRITE = 2'b11;

    // Completion status codes.
    localparam logic [1:0] RGGEN_OKAY         = 2'b00;
    localparam logic [1:0] RGGEN_EXOKAY       = 2'b01;
    localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;

endpackage

// File: rtl/rggen_access_timer.sv
// Access timer: cleared on ACCESS entry, counts stalled ACCESS cycles,
// flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
// Only instantiated when RGGEN_REG_INITIATOR_TIMEOUT_EN is defined.
module rggen_access_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Stall counter; clear has priority over increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/rggen_register_initiator.sv
// Register interface initiator: one command -> one register access -> one response.
// Optional access timeout enabled by defining RGGEN_REG_INITIATOR_TIMEOUT_EN.
module rggen_register_initiator
    import rggen_register_initiator_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_cmd_address,
    input  logic [DATA_WIDTH-1:0]     i_cmd_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp_read_data,
    output logic [1:0]                o_rsp_status,
    output logic                      o_rsp_timeout,
    output logic                      o_register_valid,
    output logic [1:0]                o_register_access,
    output logic [ADDRESS_WIDTH-1:0]  o_register_address,
    output logic [DATA_WIDTH-1:0]     o_register_write_data,
    output logic [DATA_WIDTH/8-1:0]   o_register_strobe,
    input  logic                      i_register_ready,
    input  logic [1:0]                i_register_status,
    input  logic [DATA_WIDTH-1:0]     i_register_read_data
);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(SW - 1);

    // Reject illegal configurations at elaboration.
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("rggen_register_initiator: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESPONSE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                     w_cmd_accept;
    logic                     w_access_done;
    logic                     w_timeout;
    logic [1:0]               r_access;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [SW-1:0]            r_strobe;
    logic [DATA_WIDTH-1:0]    r_read_data;
    logic [1:0]               r_status;

    assign w_cmd_accept  = i_cmd_valid && (r_state == ST_IDLE);
    assign w_access_done = i_register_ready && (r_state == ST_ACCESS);

`ifdef RGGEN_REG_INITIATOR_TIMEOUT_EN
    logic w_stall;
    logic w_expired;
    logic r_timeout;

    assign w_stall = (r_state == ST_ACCESS) && !i_register_ready;

    rggen_access_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_cmd_accept),
        .i_enable  (w_stall),
        .o_expired (w_expired)
    );

    // A ready in the expiry cycle completes normally, so only a stall can time out.
    assign w_timeout     = w_stall && w_expired;
    assign o_rsp_timeout = r_timeout;

    // Timeout flag: set on abort, held through IDLE until the next command is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_cmd_accept) begin
            r_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout     = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; ready/valid depend on state only.
    always_comb begin
        w_next_state     = r_state;
        o_cmd_ready      = 1'b0;
        o_register_valid = 1'b0;
        o_rsp_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                o_register_valid = 1'b1;
                if (i_register_ready || w_timeout) begin
                    w_next_state = ST_RESPONSE;
                end
            end
            ST_RESPONSE: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request fields latched on command accept; reads force a full strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_access     <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
        end else if (w_cmd_accept) begin
            r_access     <= i_cmd_write ? RGGEN_WRITE : RGGEN_READ;
            r_address    <= i_cmd_address & ADDR_MASK;
            r_write_data <= i_cmd_write_data;
            r_strobe     <= i_cmd_write ? i_cmd_strobe : '1;
        end
    end

    // Response capture on completion or timeout abort.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_read_data <= '0;
            r_status    <= '0;
        end else if (w_access_done) begin
            r_read_data <= (r_access == RGGEN_WRITE) ? '0 : i_register_read_data;
            r_status    <= i_register_status;
        end else if (w_timeout) begin
            r_read_data <= '0;
            r_status    <= RGGEN_SLAVE_ERROR;
        end
    end

    assign o_register_access     = r_access;
    assign o_register_address    = r_address;
    assign o_register_write_data = r_write_data;
    assign o_register_strobe     = r_strobe;
    assign o_rsp_read_data       = r_read_data;
    assign o_rsp_status          = r_status;
endmodule

// File: tb/tb_rggen_register_initiator.sv
// Testbench for rggen_register_initiator: directed cases plus randomized
// transactions checked against a transaction-level expectation model.
// Define RGGEN_REG_INITIATOR_TIMEOUT_EN to include the timeout cases.
`timescale 1ns/1ps
module tb_rggen_register_initiator;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;
`ifdef RGGEN_REG_INITIATOR_TIMEOUT_EN
    localparam int TO = 4;
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam int TO = 255;
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int BOUND = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_write_data;
    logic [SW-1:0] cmd_strobe;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_read_data;
    logic [1:0]    rsp_status;
    logic          rsp_timeout;
    logic          reg_valid;
    logic [1:0]    reg_access;
    logic [AW-1:0] reg_address;
    logic [DW-1:0] reg_write_data;
    logic [SW-1:0] reg_strobe;
    logic          reg_ready;
    logic [1:0]    reg_status;
    logic [DW-1:0] reg_read_data;

    int checks = 0;
    int errors = 0;

    rggen_register_initiator #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_cmd_valid           (cmd_valid),
        .o_cmd_ready           (cmd_ready),
        .i_cmd_write           (cmd_write),
        .i_cmd_address         (cmd_address),
        .i_cmd_write_data      (cmd_write_data),
        .i_cmd_strobe          (cmd_strobe),
        .o_rsp_valid           (rsp_valid),
        .i_rsp_ready           (rsp_ready),
        .o_rsp_read_data       (rsp_read_data),
        .o_rsp_status          (rsp_status),
        .o_rsp_timeout         (rsp_timeout),
        .o_register_valid      (reg_valid),
        .o_register_access     (reg_access),
        .o_register_address    (reg_address),
        .o_register_write_data (reg_write_data),
        .o_register_strobe     (reg_strobe),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete command/access/response transaction.
    // rdelay: number of stalled ACCESS cycles before ready (-1 = never ready).
    // rsp_hold: cycles the response is held with i_rsp_ready low.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] st, input int rdelay, input logic [1:0] rstat,
                           input logic [DW-1:0] rdata, input int rsp_hold);
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_strb;
        logic [1:0]    e_acc;
        logic [1:0]    e_status;
        logic [DW-1:0] e_data;
        bit            timed_out;
        int            e_cycles;
        int            n;

        // Expectations from the transaction rules.
        e_addr    = addr & ~AW'(SW - 1);
        e_strb    = wr ? st : {SW{1'b1}};
        e_acc     = wr ? 2'b11 : 2'b10;
        timed_out = TIMEOUT_EN && (rdelay < 0 || rdelay >= TO);
        e_cycles  = timed_out ? TO : rdelay + 1;
        e_status  = timed_out ? 2'd2 : rstat;
        e_data    = (wr || timed_out) ? '0 : rdata;

        cmd_valid      = 1'b1;
        cmd_write      = wr;
        cmd_address    = addr;
        cmd_write_data = wd;
        cmd_strobe     = st;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        tick();

        // A second command may be presented early; it must not be taken.
        cmd_valid      = 1'($urandom_range(0, 1));
        cmd_write      = 1'($urandom_range(0, 1));
        cmd_address    = AW'($urandom);
        cmd_write_data = $urandom;
        cmd_strobe     = SW'($urandom);

        n = 0;
        while (reg_valid && n < BOUND) begin
            check("reg_addr",    64'(reg_address),    64'(e_addr));
            check("reg_access",  64'(reg_access),     64'(e_acc));
            check("reg_strobe",  64'(reg_strobe),     64'(e_strb));
            check("reg_wdata",   64'(reg_write_data), 64'(wd));
            check("cmd_ready_busy", 64'(cmd_ready),   64'd0);
            if (n == 0) check("timeout_clear", 64'(rsp_timeout), 64'd0);
            if (n == rdelay) begin
                reg_ready     = 1'b1;
                reg_status    = rstat;
                reg_read_data = rdata;
            end else begin
                reg_ready     = 1'b0;
                reg_status    = 2'($urandom);
                reg_read_data = $urandom;
            end
            tick();
            n++;
        end
        reg_ready = 1'b0;
        check("access_bound", 64'(n < BOUND), 64'd1);
        check("valid_cycles", 64'(n), 64'(e_cycles));
        check("latency", 64'(n + 1), 64'(e_cycles + 1));

        for (int h = 0; h <= rsp_hold; h++) begin
            check("rsp_valid",  64'(rsp_valid),     64'd1);
            check("rsp_data",   64'(rsp_read_data), 64'(e_data));
            check("rsp_status", 64'(rsp_status),    64'(e_status));
            check("rsp_tmo",    64'(rsp_timeout),   64'(timed_out));
            check("cmd_ready_rsp", 64'(cmd_ready),  64'd0);
            check("reg_valid_rsp", 64'(reg_valid),  64'd0);
            rsp_ready     = (h == rsp_hold);
            reg_ready     = 1'($urandom_range(0, 1));
            reg_status    = 2'($urandom);
            reg_read_data = $urandom;
            tick();
        end
        rsp_ready = 1'b0;
        reg_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_done",      64'(rsp_valid),   64'd0);
        check("cmd_ready_ret", 64'(cmd_ready),   64'd1);
        check("reg_valid_idle", 64'(reg_valid),  64'd0);
        check("tmo_sticky",    64'(rsp_timeout), 64'(timed_out));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
        cmd_write_data = '0; cmd_strobe = '0; rsp_ready = 1'b0;
        reg_ready = 1'b0; reg_status = '0; reg_read_data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst_cmd_ready", 64'(cmd_ready),      64'd1);
        check("rst_rsp_valid", 64'(rsp_valid),      64'd0);
        check("rst_reg_valid", 64'(reg_valid),      64'd0);
        check("rst_access",    64'(reg_access),     64'd0);
        check("rst_addr",      64'(reg_address),    64'd0);
        check("rst_wdata",     64'(reg_write_data), 64'd0);
        check("rst_strobe",    64'(reg_strobe),     64'd0);
        check("rst_rdata",     64'(rsp_read_data),  64'd0);
        check("rst_status",    64'(rsp_status),     64'd0);
        check("rst_tmo",       64'(rsp_timeout),    64'd0);

        // Stray ready inputs while idle are ignored.
        rsp_ready = 1'b1; reg_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
            check("idle_reg_valid", 64'(reg_valid), 64'd0);
        end
        rsp_ready = 1'b0; reg_ready = 1'b0;

        // Directed cases.
        run_txn(1'b0, 8'h10, 32'h0, 4'h0, 2, 2'd0, 32'hDEADBEEF, 0);
        run_txn(1'b1, 8'h13, 32'h12345678, 4'b0101, 0, 2'd0, 32'hCAFEF00D, 0);
        run_txn(1'b0, 8'h24, 32'h0, 4'h0, 0, 2'd1, 32'h00C0FFEE, 5);
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 8'(8'h40 + 4 * i), 32'(i + 1), 4'hF, 0, 2'd0, 32'h0, 0);
        run_txn(1'b0, 8'h3C, 32'h0, 4'h0, 1, 2'd3, 32'hA5A55A5A, 0);
        run_txn(1'b1, 8'h08, 32'hFFFF0000, 4'b0000, 0, 2'd2, 32'h0, 1);

        // Randomized transactions.
        for (int i = 0; i < 40; i++)
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, 5)), 2'($urandom), $urandom,
                    int'($urandom_range(0, 3)));

`ifdef RGGEN_REG_INITIATOR_TIMEOUT_EN
        // Never ready: aborts after TO cycles; ready in the last allowed cycle still completes.
        run_txn(1'b0, 8'h20, 32'h0, 4'h0, -1, 2'd0, 32'h11111111, 0);
        run_txn(1'b0, 8'h24, 32'h0, 4'h0, TO - 1, 2'd0, 32'h22222222, 0);
        run_txn(1'b1, 8'h28, 32'h5, 4'h3, -1, 2'd0, 32'h0, 2);
        run_txn(1'b1, 8'h2C, 32'h6, 4'h1, 0, 2'd1, 32'h0, 0);
`endif

        // Reset while in ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h44;
        tick();
        cmd_valid = 1'b0;
        check("pre_rst_access", 64'(reg_valid), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_acc_valid", 64'(reg_valid), 64'd0);
        check("rst_acc_ready", 64'(cmd_ready), 64'd1);
        check("rst_acc_rsp",   64'(rsp_valid), 64'd0);

        // Reset while holding a response.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h48;
        tick();
        cmd_valid = 1'b0; reg_ready = 1'b1; reg_read_data = 32'h77; reg_status = 2'd1;
        tick();
        reg_ready = 1'b0;
        check("pre_rst_rsp", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_rsp_valid2", 64'(rsp_valid),     64'd0);
        check("rst_rsp_data2",  64'(rsp_read_data), 64'd0);
        check("rst_rsp_ready2", 64'(cmd_ready),     64'd1);
        tick();
        check("rst_rsp_stay",   64'(rsp_valid),     64'd0);

        // Normal operation resumes after reset.
        run_txn(1'b0, 8'h4C, 32'h0, 4'h0, 1, 2'd0, 32'h13572468, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        errors++;
        $display("FAIL sim_timeout: got no finish expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end
endmodule
